// File: rtl/axil_axis_bridge_if.sv
// AXI4-Lite slave-side bus bundle for axil_axis_bridge.
// The bridge uses the slave modport; a bus master or bench uses master.
interface axil_axis_bridge_if;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_awprot;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic        s_axi_arprot;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready,
        input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        input  s_axi_rready
    );

    modport master (
        output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bresp, s_axi_bvalid,
        output s_axi_bready,
        output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        output s_axi_rready
    );
endinterface

// File: rtl/axil_axis_bridge.sv
// AXI4-Lite slave to NUM_CH TX/RX AXI-Stream pairs with per-channel FWFT FIFOs.
// Optional per-channel interrupts are built when AXIL_AXIS_IRQ_EN is defined.
module axil_axis_bridge #(
    parameter int NUM_CH   = 2,
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    axil_axis_bridge_if.slave      axil,
    output logic [32*NUM_CH-1:0]   m_axis_tdata,
    output logic [NUM_CH-1:0]      m_axis_tvalid,
    input  logic [NUM_CH-1:0]      m_axis_tready,
    input  logic [32*NUM_CH-1:0]   s_axis_tdata,
    input  logic [NUM_CH-1:0]      s_axis_tvalid,
`ifdef AXIL_AXIS_IRQ_EN
    output logic [NUM_CH-1:0]      s_axis_tready,
    output logic [NUM_CH-1:0]      irq
`else
    output logic [NUM_CH-1:0]      s_axis_tready
`endif
);

    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ADDR_HI = 3 + CH_W;
    localparam int TX_AW   = $clog2(TX_DEPTH);
    localparam int TX_LW   = TX_AW + 1;
    localparam int RX_AW   = $clog2(RX_DEPTH);
    localparam int RX_LW   = RX_AW + 1;
    localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CTRL    = 2'd2;

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_EXEC, R_RESP} rstate_e;

    // Per-channel FIFO status and control vectors
    logic [NUM_CH-1:0] tx_empty, tx_full, rx_empty, rx_full;
    logic [NUM_CH-1:0] tx_push, tx_flush, rx_flush, rx_pop, ctrl_wr;
    logic [NUM_CH-1:0] tx_ie, rx_ie;
    logic [NUM_CH-1:0] w_sel, r_sel;
    logic [7:0]        tx_lvl8 [NUM_CH];
    logic [7:0]        rx_lvl8 [NUM_CH];
    logic [31:0]       rx_head [NUM_CH];

    // Write channel state
    wstate_e          w_state_q, w_state_d;
    logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [1:0]       bresp_q, bresp_d;
    logic [ADDR_HI:2] awaddr_q;
    logic [31:0]      wdata_q;
    logic             wstrb0_q;
    logic             awready, wready, bvalid, aw_hs, w_hs, w_exec;
    logic [1:0]       w_resp;
    logic             push_req, ctrl_req;
    logic [CH_W-1:0]  w_ch;
    logic [1:0]       w_reg;

    // Read channel state
    rstate_e          r_state_q, r_state_d;
    logic [1:0]       rresp_q, rresp_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [ADDR_HI:2] araddr_q;
    logic             arready, rvalid, ar_hs, r_exec;
    logic [1:0]       r_resp;
    logic [31:0]      r_data, st_word, ctrl_word, head_sel;
    logic             rxe_sel, pop_req;
    logic [CH_W-1:0]  r_ch;
    logic [1:0]       r_reg;

    logic unused_ok;
    assign unused_ok = ^{axil.s_axi_awaddr[31:ADDR_HI+1], axil.s_axi_awaddr[1:0],
                         axil.s_axi_araddr[31:ADDR_HI+1], axil.s_axi_araddr[1:0],
                         axil.s_axi_awprot, axil.s_axi_arprot, axil.s_axi_wstrb[3:1]};

    assign axil.s_axi_awready = awready;
    assign axil.s_axi_wready  = wready;
    assign axil.s_axi_bvalid  = bvalid;
    assign axil.s_axi_bresp   = bresp_q;
    assign axil.s_axi_arready = arready;
    assign axil.s_axi_rvalid  = rvalid;
    assign axil.s_axi_rresp   = rresp_q;
    assign axil.s_axi_rdata   = rdata_q;

    // AW and W may arrive in any order; each is held off once captured
    always_comb begin
        w_state_d = w_state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        bresp_d   = bresp_q;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        w_exec    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                awready = !aw_done_q;
                wready  = !w_done_q;
                aw_hs   = axil.s_axi_awvalid && awready;
                w_hs    = axil.s_axi_wvalid && wready;
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    w_state_d = W_EXEC;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            W_EXEC: begin
                w_exec    = 1'b1;
                bresp_d   = w_resp;
                w_state_d = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (axil.s_axi_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            bresp_q   <= bresp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (aw_hs) awaddr_q <= axil.s_axi_awaddr[ADDR_HI:2];
        if (w_hs) begin
            wdata_q  <= axil.s_axi_wdata;
            wstrb0_q <= axil.s_axi_wstrb[0];
        end
        if (ar_hs) araddr_q <= axil.s_axi_araddr[ADDR_HI:2];
    end

    assign w_reg = awaddr_q[3:2];
    assign w_ch  = awaddr_q[ADDR_HI:4];

    always_comb begin
        w_resp   = RESP_OKAY;
        push_req = 1'b0;
        ctrl_req = 1'b0;
        for (int c = 0; c < NUM_CH; c++) w_sel[c] = (w_ch == CH_W'(c));
        if (({1'b0, w_ch} >= NUM_CH_L) || (w_reg == REG_STATUS) || (w_reg == 2'd3)) begin
            w_resp = RESP_SLVERR;
        end else if (w_reg == REG_DATA) begin
            if (|(tx_full & w_sel)) w_resp = RESP_SLVERR;
            else                    push_req = 1'b1;
        end else begin
            ctrl_req = wstrb0_q;
        end
    end

    assign tx_push  = {NUM_CH{w_exec & push_req}} & w_sel;
    assign ctrl_wr  = {NUM_CH{w_exec & ctrl_req}} & w_sel;
    assign tx_flush = ctrl_wr & {NUM_CH{wdata_q[0]}};
    assign rx_flush = ctrl_wr & {NUM_CH{wdata_q[1]}};

    // Read FSM: rdata/rresp latched in R_EXEC and held through R_RESP
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        arready   = 1'b0;
        rvalid    = 1'b0;
        ar_hs     = 1'b0;
        r_exec    = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                arready = 1'b1;
                ar_hs   = axil.s_axi_arvalid;
                if (ar_hs) r_state_d = R_EXEC;
            end
            R_EXEC: begin
                r_exec    = 1'b1;
                rdata_d   = r_data;
                rresp_d   = r_resp;
                r_state_d = R_RESP;
            end
            R_RESP: begin
                rvalid = 1'b1;
                if (axil.s_axi_rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign r_reg = araddr_q[3:2];
    assign r_ch  = araddr_q[ADDR_HI:4];

    always_comb begin
        r_resp    = RESP_OKAY;
        r_data    = '0;
        pop_req   = 1'b0;
        st_word   = '0;
        ctrl_word = '0;
        head_sel  = '0;
        rxe_sel   = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            r_sel[c] = (r_ch == CH_W'(c));
            if (r_sel[c]) begin
                st_word   = {8'h00, rx_lvl8[c], tx_lvl8[c], 4'h0,
                             rx_full[c], rx_empty[c], tx_full[c], tx_empty[c]};
                ctrl_word = {28'h0, rx_ie[c], tx_ie[c], 2'b00};
                head_sel  = rx_head[c];
                rxe_sel   = rx_empty[c];
            end
        end
        if (({1'b0, r_ch} >= NUM_CH_L) || (r_reg == 2'd3)) begin
            r_resp = RESP_SLVERR;
        end else begin
            case (r_reg)
                REG_DATA: begin
                    if (rxe_sel) begin
                        r_resp = RESP_SLVERR;
                    end else begin
                        r_data  = head_sel;
                        pop_req = 1'b1;
                    end
                end
                REG_STATUS: r_data = st_word;
                default:    r_data = ctrl_word;
            endcase
        end
    end

    assign rx_pop = {NUM_CH{r_exec & pop_req}} & r_sel;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [31:0]      tx_mem [TX_DEPTH];
        logic [TX_AW-1:0] tx_wr_q, tx_rd_q;
        logic [TX_LW-1:0] tx_lvl_q;
        logic [31:0]      rx_mem [RX_DEPTH];
        logic [RX_AW-1:0] rx_wr_q, rx_rd_q;
        logic [RX_LW-1:0] rx_lvl_q;
        logic             tx_pop, rx_push;

        assign tx_empty[c] = (tx_lvl_q == '0);
        assign tx_full[c]  = (tx_lvl_q == TX_LW'(TX_DEPTH));
        assign rx_empty[c] = (rx_lvl_q == '0);
        assign rx_full[c]  = (rx_lvl_q == RX_LW'(RX_DEPTH));
        assign tx_lvl8[c]  = 8'(tx_lvl_q);
        assign rx_lvl8[c]  = 8'(rx_lvl_q);

        assign m_axis_tvalid[c]         = !tx_empty[c];
        assign m_axis_tdata[32*c +: 32] = tx_mem[tx_rd_q];
        assign s_axis_tready[c]         = !rx_full[c];
        assign rx_head[c]               = rx_mem[rx_rd_q];
        assign tx_pop  = m_axis_tvalid[c] & m_axis_tready[c];
        assign rx_push = s_axis_tvalid[c] & s_axis_tready[c];

        always_ff @(posedge clk) begin
            if (tx_push[c]) tx_mem[tx_wr_q] <= wdata_q;
            if (rx_push && !rx_flush[c]) rx_mem[rx_wr_q] <= s_axis_tdata[32*c +: 32];
        end

        // Flush overrides any stream beat landing in the same cycle
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tx_wr_q  <= '0;
                tx_rd_q  <= '0;
                tx_lvl_q <= '0;
            end else if (tx_flush[c]) begin
                tx_wr_q  <= '0;
                tx_rd_q  <= '0;
                tx_lvl_q <= '0;
            end else begin
                if (tx_push[c]) tx_wr_q <= tx_wr_q + TX_AW'(1);
                if (tx_pop)     tx_rd_q <= tx_rd_q + TX_AW'(1);
                if (tx_push[c] && !tx_pop)      tx_lvl_q <= tx_lvl_q + TX_LW'(1);
                else if (!tx_push[c] && tx_pop) tx_lvl_q <= tx_lvl_q - TX_LW'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rx_wr_q  <= '0;
                rx_rd_q  <= '0;
                rx_lvl_q <= '0;
            end else if (rx_flush[c]) begin
                rx_wr_q  <= '0;
                rx_rd_q  <= '0;
                rx_lvl_q <= '0;
            end else begin
                if (rx_push)   rx_wr_q <= rx_wr_q + RX_AW'(1);
                if (rx_pop[c]) rx_rd_q <= rx_rd_q + RX_AW'(1);
                if (rx_push && !rx_pop[c])      rx_lvl_q <= rx_lvl_q + RX_LW'(1);
                else if (!rx_push && rx_pop[c]) rx_lvl_q <= rx_lvl_q - RX_LW'(1);
            end
        end

`ifdef AXIL_AXIS_IRQ_EN
        logic tx_ie_q, rx_ie_q, irq_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tx_ie_q <= 1'b0;
                rx_ie_q <= 1'b0;
                irq_q   <= 1'b0;
            end else begin
                if (ctrl_wr[c]) begin
                    tx_ie_q <= wdata_q[2];
                    rx_ie_q <= wdata_q[3];
                end
                irq_q <= (tx_empty[c] & tx_ie_q) | (!rx_empty[c] & rx_ie_q);
            end
        end

        assign tx_ie[c] = tx_ie_q;
        assign rx_ie[c] = rx_ie_q;
        assign irq[c]   = irq_q;
`else
        assign tx_ie[c] = 1'b0;
        assign rx_ie[c] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_axil_axis_bridge.sv
// Scoreboard bench for axil_axis_bridge: tasks queue expected B/R/TX results,
// a negedge monitor pops and compares whenever the DUT completes a transfer.
module tb_axil_axis_bridge;
    localparam int NUM_CH = 3;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_axis_bridge_if bus ();
    logic [32*NUM_CH-1:0] m_axis_tdata;
    logic [NUM_CH-1:0]    m_axis_tvalid;
    logic [NUM_CH-1:0]    m_axis_tready;
    logic [32*NUM_CH-1:0] s_axis_tdata;
    logic [NUM_CH-1:0]    s_axis_tvalid;
    logic [NUM_CH-1:0]    s_axis_tready;
`ifdef AXIL_AXIS_IRQ_EN
    logic [NUM_CH-1:0]    irq;
`endif

    axil_axis_bridge #(.NUM_CH(NUM_CH), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .axil          (bus),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
`ifdef AXIL_AXIS_IRQ_EN
        .s_axis_tready (s_axis_tready),
        .irq           (irq)
`else
        .s_axis_tready (s_axis_tready)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [1:0]  bq [$];
    logic [33:0] rq [$];
    logic [31:0] txq0 [$];
    logic [31:0] txq1 [$];
    logic [31:0] txq2 [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Monitor: compare every completed B, R and TX transfer against the queues
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.s_axi_bvalid && bus.s_axi_bready) begin
                if (bq.size() == 0) fail_now("bresp_unexpected");
                else chk("bresp", {30'b0, bus.s_axi_bresp}, {30'b0, bq.pop_front()});
            end
            if (bus.s_axi_rvalid && bus.s_axi_rready) begin
                if (rq.size() == 0) fail_now("rdata_unexpected");
                else begin
                    logic [33:0] e;
                    e = rq.pop_front();
                    chk("rdata", bus.s_axi_rdata, e[31:0]);
                    chk("rresp", {30'b0, bus.s_axi_rresp}, {30'b0, e[33:32]});
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (m_axis_tvalid[c] && m_axis_tready[c]) begin
                    logic [31:0] d;
                    d = m_axis_tdata[32*c +: 32];
                    case (c)
                        0: if (txq0.size() == 0) fail_now("tx0_unexpected"); else chk("tx0_beat", d, txq0.pop_front());
                        1: if (txq1.size() == 0) fail_now("tx1_unexpected"); else chk("tx1_beat", d, txq1.pop_front());
                        default: if (txq2.size() == 0) fail_now("tx2_unexpected"); else chk("tx2_beat", d, txq2.pop_front());
                    endcase
                end
            end
        end
    end

    task automatic axil_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              input logic [1:0] exp, input bit inj, input logic [31:0] inj_data,
                              output int lat);
        bit aw_pend, w_pend, aw_fire, w_fire, got;
        int n;
        bq.push_back(exp);
        @(posedge clk); #1;
        bus.s_axi_awaddr = addr; bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wdata = data; bus.s_axi_wstrb = strb; bus.s_axi_wvalid = 1'b1;
        aw_pend = 1'b1; w_pend = 1'b1; n = 0;
        while ((aw_pend || w_pend) && n < 50) begin
            @(negedge clk);
            aw_fire = aw_pend && bus.s_axi_awready;
            w_fire  = w_pend && bus.s_axi_wready;
            @(posedge clk); #1;
            if (aw_fire) begin aw_pend = 1'b0; bus.s_axi_awvalid = 1'b0; end
            if (w_fire)  begin w_pend = 1'b0;  bus.s_axi_wvalid = 1'b0; end
            n++;
        end
        if (aw_pend || w_pend) fail_now("write_addr_data_timeout");
        if (inj) begin
            s_axis_tdata[31:0] = inj_data;
            s_axis_tvalid[0] = 1'b1;
        end
        lat = 0; got = 1'b0;
        while (!got && lat < 50) begin
            @(negedge clk); lat++;
            if (bus.s_axi_bvalid && bus.s_axi_bready) got = 1'b1;
            else begin
                @(posedge clk); #1;
                s_axis_tvalid[0] = 1'b0;
            end
        end
        if (!got) fail_now("write_resp_timeout");
        @(posedge clk); #1;
    endtask

    task automatic axil_read(input logic [31:0] addr, input logic [31:0] exp_data,
                             input logic [1:0] exp_resp, output int lat);
        bit fired, got;
        int n;
        rq.push_back({exp_resp, exp_data});
        @(posedge clk); #1;
        bus.s_axi_araddr = addr; bus.s_axi_arvalid = 1'b1;
        fired = 1'b0; n = 0;
        while (!fired && n < 50) begin
            @(negedge clk);
            fired = bus.s_axi_arready;
            @(posedge clk); #1;
            n++;
        end
        bus.s_axi_arvalid = 1'b0;
        if (!fired) fail_now("read_addr_timeout");
        lat = 0; got = 1'b0;
        while (!got && lat < 50) begin
            @(negedge clk); lat++;
            if (bus.s_axi_rvalid && bus.s_axi_rready) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!got) fail_now("read_resp_timeout");
        @(posedge clk); #1;
    endtask

    task automatic rx_beat(input int ch, input logic [31:0] data);
        @(posedge clk); #1;
        s_axis_tdata[32*ch +: 32] = data;
        s_axis_tvalid[ch] = 1'b1;
        @(posedge clk); #1;
        s_axis_tvalid[ch] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bus.s_axi_awaddr = '0; bus.s_axi_awprot = 1'b0; bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wvalid = 1'b0;
        bus.s_axi_bready = 1'b1;
        bus.s_axi_araddr = '0; bus.s_axi_arprot = 1'b0; bus.s_axi_arvalid = 1'b0;
        bus.s_axi_rready = 1'b1;
        m_axis_tready = '1;
        s_axis_tdata = '0;
        s_axis_tvalid = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", {31'b0, bus.s_axi_awready}, 32'd1);
        chk("rst_wready",  {31'b0, bus.s_axi_wready},  32'd1);
        chk("rst_arready", {31'b0, bus.s_axi_arready}, 32'd1);
        chk("rst_bvalid",  {31'b0, bus.s_axi_bvalid},  32'd0);
        chk("rst_rvalid",  {31'b0, bus.s_axi_rvalid},  32'd0);
        chk("rst_rdata",   bus.s_axi_rdata, 32'd0);
        chk("rst_tvalid",  {29'b0, m_axis_tvalid}, 32'd0);
        chk("rst_tready",  {29'b0, s_axis_tready}, 32'd7);
        rst = 1'b0;

        // STATUS ch0 after reset, with latency
        axil_read(32'h04, 32'h0000_0005, OKAY, lat);
        chk("read_latency", lat, 32'd2);

        // Fill ch1 TX while its stream is stalled
        m_axis_tready[1] = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            txq1.push_back(32'hA5A5_0000 + i);
            axil_write(32'h10, 32'hA5A5_0000 + i, 4'hF, OKAY, 1'b0, 32'h0, lat);
            if (i == 1) chk("write_latency", lat, 32'd2);
        end
        axil_read(32'h14, 32'h0000_0806, OKAY, lat);
        axil_write(32'h10, 32'hA5A5_0009, 4'hF, SLVERR, 1'b0, 32'h0, lat);
        @(posedge clk); #1;
        m_axis_tready[1] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("tx1_drained_tvalid", {31'b0, m_axis_tvalid[1]}, 32'd0);
        chk("tx1_drained_queue", txq1.size(), 32'd0);

        // RX ch0: three beats then four DATA reads
        rx_beat(0, 32'hC0DE_0001);
        rx_beat(0, 32'hC0DE_0002);
        rx_beat(0, 32'hC0DE_0003);
        axil_read(32'h04, 32'h0003_0001, OKAY, lat);
        axil_read(32'h00, 32'hC0DE_0001, OKAY, lat);
        axil_read(32'h00, 32'hC0DE_0002, OKAY, lat);
        axil_read(32'h00, 32'hC0DE_0003, OKAY, lat);
        axil_read(32'h00, 32'h0000_0000, SLVERR, lat);

        // W before AW with a gap, then bready held low
        m_axis_tready[0] = 1'b0;
        bus.s_axi_bready = 1'b0;
        bq.push_back(OKAY);
        txq0.push_back(32'h1234_5678);
        @(posedge clk); #1;
        bus.s_axi_wdata = 32'h1234_5678; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
        @(negedge clk);
        chk("w_first_wready", {31'b0, bus.s_axi_wready}, 32'd1);
        @(posedge clk); #1;
        bus.s_axi_wvalid = 1'b0;
        chk("w_held_off", {31'b0, bus.s_axi_wready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        bus.s_axi_awaddr = 32'h00; bus.s_axi_awvalid = 1'b1;
        @(negedge clk);
        chk("aw_late_awready", {31'b0, bus.s_axi_awready}, 32'd1);
        @(posedge clk); #1;
        bus.s_axi_awvalid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("bvalid_held", {31'b0, bus.s_axi_bvalid}, 32'd1);
            chk("bresp_stable", {30'b0, bus.s_axi_bresp}, {30'b0, OKAY});
            @(posedge clk); #1;
        end
        bus.s_axi_bready = 1'b1;
        @(posedge clk); #1;
        chk("bvalid_cleared", {31'b0, bus.s_axi_bvalid}, 32'd0);
        axil_read(32'h04, 32'h0000_0104, OKAY, lat);
        m_axis_tready[0] = 1'b1;
        repeat (2) @(posedge clk);

        // CTRL: strobe gating, then flush racing an RX beat
        m_axis_tready[0] = 1'b0;
        axil_write(32'h00, 32'hDEAD_0001, 4'hF, OKAY, 1'b0, 32'h0, lat);
        axil_write(32'h00, 32'hDEAD_0002, 4'h0, OKAY, 1'b0, 32'h0, lat);
        rx_beat(0, 32'hBEEF_0001);
        axil_write(32'h08, 32'h0000_0003, 4'hE, OKAY, 1'b0, 32'h0, lat);
        axil_read(32'h04, 32'h0001_0200, OKAY, lat);
        axil_write(32'h08, 32'h0000_0003, 4'h1, OKAY, 1'b1, 32'hBEEF_0002, lat);
        axil_read(32'h04, 32'h0000_0005, OKAY, lat);
        chk("flush_tvalid", {31'b0, m_axis_tvalid[0]}, 32'd0);
        m_axis_tready[0] = 1'b1;
        repeat (3) @(posedge clk);

        // Decode errors and ignored upper address bits
        axil_read(32'h30, 32'h0, SLVERR, lat);
        axil_write(32'h30, 32'h1, 4'hF, SLVERR, 1'b0, 32'h0, lat);
        axil_read(32'h0C, 32'h0, SLVERR, lat);
        axil_write(32'h1C, 32'h1, 4'hF, SLVERR, 1'b0, 32'h0, lat);
        axil_write(32'h04, 32'h1, 4'hF, SLVERR, 1'b0, 32'h0, lat);
        axil_read(32'h08, 32'h0, OKAY, lat);
        axil_read(32'hF000_0004, 32'h0000_0005, OKAY, lat);

`ifdef AXIL_AXIS_IRQ_EN
        axil_write(32'h08, 32'h0000_0008, 4'h1, OKAY, 1'b0, 32'h0, lat);
        axil_read(32'h08, 32'h0000_0008, OKAY, lat);
        chk("irq_idle", {29'b0, irq}, 32'd0);
        @(posedge clk); #1;
        s_axis_tdata[31:0] = 32'h0000_0099; s_axis_tvalid[0] = 1'b1;
        @(posedge clk); #1;
        s_axis_tvalid[0] = 1'b0;
        chk("irq_lag", {31'b0, irq[0]}, 32'd0);
        @(posedge clk); #1;
        chk("irq_set", {31'b0, irq[0]}, 32'd1);
        axil_read(32'h00, 32'h0000_0099, OKAY, lat);
        chk("irq_clear", {31'b0, irq[0]}, 32'd0);
        axil_write(32'h08, 32'h0000_0000, 4'h1, OKAY, 1'b0, 32'h0, lat);
`endif

        // Reset while a read response is pending on ch2
        m_axis_tready[2] = 1'b0;
        axil_write(32'h20, 32'h0000_0066, 4'hF, OKAY, 1'b0, 32'h0, lat);
        rx_beat(2, 32'h0000_0077);
        bus.s_axi_rready = 1'b0;
        @(posedge clk); #1;
        bus.s_axi_araddr = 32'h20; bus.s_axi_arvalid = 1'b1;
        @(posedge clk); #1;
        bus.s_axi_arvalid = 1'b0;
        @(posedge clk); #1;
        chk("pending_rvalid", {31'b0, bus.s_axi_rvalid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_rvalid",  {31'b0, bus.s_axi_rvalid}, 32'd0);
        chk("midrst_rdata",   bus.s_axi_rdata, 32'd0);
        chk("midrst_arready", {31'b0, bus.s_axi_arready}, 32'd1);
        chk("midrst_tvalid",  {29'b0, m_axis_tvalid}, 32'd0);
        chk("midrst_tready",  {29'b0, s_axis_tready}, 32'd7);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.s_axi_rready = 1'b1;
        m_axis_tready[2] = 1'b1;
        axil_read(32'h24, 32'h0000_0005, OKAY, lat);

        repeat (5) @(posedge clk);
        #1;
        chk("bq_empty",  bq.size(), 32'd0);
        chk("rq_empty",  rq.size(), 32'd0);
        chk("txq_empty", txq0.size() + txq1.size() + txq2.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
